rf_scoreboard: RTL

- Register-busy scoreboard in front of the dual-issue 4-read/2-write register file.
- Tracks outstanding writes per architectural register between issue and writeback.
- Grants issue to slot A and slot B only when their sources are free or are being written back this cycle, which is the case the RF write-to-read bypass covers.
- Sits between decode/issue and the two execution pipes; its write-release inputs mirror the two RF write ports.

---
 rtl/rf_scoreboard_if.sv | 39 +++
 rtl/rf_scoreboard.sv | 98 +++++++++
 2 files changed

// File: rtl/rf_scoreboard_if.sv
// rtl/rf_scoreboard_if.sv - issue/writeback bundle between decode, scoreboard and the RF write ports
//
// master: decode/issue plus writeback side. It drives the slot A/B issue requests and the
//         wb release lines, and it receives iss_ready_a/iss_ready_b.
// slave : the scoreboard. It samples the requests and releases, and it drives the readies.
interface rf_scoreboard_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  iss_valid_a;
    logic [ADDR_WIDTH-1:0] iss_rs1_a;
    logic [ADDR_WIDTH-1:0] iss_rs2_a;
    logic [ADDR_WIDTH-1:0] iss_rd_a;
    logic                  iss_wen_a;
    logic                  iss_valid_b;
    logic [ADDR_WIDTH-1:0] iss_rs1_b;
    logic [ADDR_WIDTH-1:0] iss_rs2_b;
    logic [ADDR_WIDTH-1:0] iss_rd_b;
    logic                  iss_wen_b;
    logic                  iss_ready_a;
    logic                  iss_ready_b;
    logic                  wb_we_a;
    logic [ADDR_WIDTH-1:0] wb_waddr_a;
    logic                  wb_we_b;
    logic [ADDR_WIDTH-1:0] wb_waddr_b;

    modport master (
        output iss_valid_a, iss_rs1_a, iss_rs2_a, iss_rd_a, iss_wen_a,
        output iss_valid_b, iss_rs1_b, iss_rs2_b, iss_rd_b, iss_wen_b,
        output wb_we_a, wb_waddr_a, wb_we_b, wb_waddr_b,
        input  iss_ready_a, iss_ready_b
    );

    modport slave (
        input  iss_valid_a, iss_rs1_a, iss_rs2_a, iss_rd_a, iss_wen_a,
        input  iss_valid_b, iss_rs1_b, iss_rs2_b, iss_rd_b, iss_wen_b,
        input  wb_we_a, wb_waddr_a, wb_we_b, wb_waddr_b,
        output iss_ready_a, iss_ready_b
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write scoreboard for dual-issue 4R/2W register file
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   sb (slave)     : slot A/B issue requests with their combinational readies, and the two
//                    writeback release ports that mirror the RF write ports
//   flush          : drops every outstanding write at the next edge
//   busy_mask      : registered, bit r set while register r has pending writes
//   err_underflow  : sticky, set when a register is released with no write pending
module rf_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    rf_scoreboard_if.slave               sb,
    input  logic                         flush,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy_mask,
    output logic                         err_underflow
);
    localparam int NREG = 1 << ADDR_WIDTH;
    // One spare bit so that cnt + inc and the release count compare without wrapping.
    localparam int W = CNT_W + 1;
    localparam logic [W-1:0] CMAX = W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [W-1:0]     rel_n   [NREG];
    logic [W-1:0]     inc_n   [NREG];
    logic [NREG-1:0]  free_v;
    logic [NREG-1:0]  uf_v;
    logic             ready_a;
    logic             ready_b;
    logic             raw_ab;
    logic             waw_ab;
    logic [W-1:0]     room_b;

    always_comb begin
        // Releases this cycle. A register that is written back now counts as readable
        // because the RF forwards its write data to the read ports.
        for (int r = 0; r < NREG; r++) begin
            rel_n[r] = '0;
            if (r != 0) begin
                rel_n[r] = W'(sb.wb_we_a && (sb.wb_waddr_a == ADDR_WIDTH'(r)))
                         + W'(sb.wb_we_b && (sb.wb_waddr_b == ADDR_WIDTH'(r)));
            end
            free_v[r] = (r == 0) || (W'(cnt[r]) <= rel_n[r]);
        end

        ready_a = !rst && !flush && sb.iss_valid_a
               && free_v[sb.iss_rs1_a] && free_v[sb.iss_rs2_a]
               && (!sb.iss_wen_a || (sb.iss_rd_a == '0) || (W'(cnt[sb.iss_rd_a]) < CMAX));

        // B is younger. It must not read A's result and must leave room for A's write to the same rd.
        raw_ab  = sb.iss_wen_a && (sb.iss_rd_a != '0)
               && ((sb.iss_rs1_b == sb.iss_rd_a) || (sb.iss_rs2_b == sb.iss_rd_a));
        waw_ab  = sb.iss_wen_a && (sb.iss_rd_a == sb.iss_rd_b);
        room_b  = W'(cnt[sb.iss_rd_b]) + W'(waw_ab);
        ready_b = ready_a && sb.iss_valid_b
               && free_v[sb.iss_rs1_b] && free_v[sb.iss_rs2_b] && !raw_ab
               && (!sb.iss_wen_b || (sb.iss_rd_b == '0) || (room_b < CMAX));

        for (int r = 0; r < NREG; r++) begin
            inc_n[r] = '0;
            if (r != 0) begin
                inc_n[r] = W'(ready_a && sb.iss_wen_a && (sb.iss_rd_a == ADDR_WIDTH'(r)))
                         + W'(ready_b && sb.iss_wen_b && (sb.iss_rd_b == ADDR_WIDTH'(r)));
            end
            uf_v[r]    = rel_n[r] > (W'(cnt[r]) + inc_n[r]);
            cnt_nxt[r] = uf_v[r] ? '0 : CNT_W'(W'(cnt[r]) + inc_n[r] - rel_n[r]);
        end
    end

    assign sb.iss_ready_a = ready_a;
    assign sb.iss_ready_b = ready_b;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // Reset and flush both drop every outstanding write. Releases seen in the same
            // cycle are ignored, so they cannot raise the error flag.
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            busy_mask <= '0;
            if (rst) begin
                err_underflow <= 1'b0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r]       <= cnt_nxt[r];
                busy_mask[r] <= (cnt_nxt[r] != '0);
            end
            if (|uf_v) begin
                err_underflow <= 1'b1;
            end
        end
    end
endmodule
